lsq_mem_issue_arbiter: RTL and testbench

//  Arbitrates load/store address results from the two ALU issue lanes into the single LSQ address port.

---
 rtl/lsq_mem_issue_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_lsq_mem_issue_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_mem_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lsq_mem_issue_arbiter
// Description : Collects load/store address results from two ALU issue lanes
//               into per-lane FIFOs. A round-robin arbiter then drains the FIFO
//               heads into the single LSQ address port over valid/ready.
//               Results with non-memory opcodes are dropped at the input.
// Ports       : clk_i/rst_i (async, active high), flush_i (sync flush)
//               lane n: validn_i, resultn_i, op_funcn_i, tagn_i -> readyn_o
//               LSQ   : lsq_valid_o, lsq_ready_i, address_o, tag_o,
//                       is_store_o, lane_o (0 = lane 1, 1 = lane 2)
//               LSQ_ARB_STATS_EN adds grant1_cnt_o, grant2_cnt_o and
//               stall_cnt_o (16-bit saturating, cleared by reset only)
// Revision    : 1.0 - initial release
// ============================================================================
module lsq_mem_issue_arbiter #(
    parameter int                OPRAND_WIDTH = 32,
    parameter int                OP_WIDTH     = 7,
    parameter int                TAG_WIDTH    = 6,
    parameter int                DEPTH        = 2,
    parameter logic [OP_WIDTH-1:0] STORE      = 7'b0100011,
    parameter logic [OP_WIDTH-1:0] LOAD       = 7'b0000011
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    valid1_i,
    input  logic [OPRAND_WIDTH-1:0] result1_i,
    input  logic [OP_WIDTH-1:0]     op_func1_i,
    input  logic [TAG_WIDTH-1:0]    tag1_i,
    output logic                    ready1_o,
    input  logic                    valid2_i,
    input  logic [OPRAND_WIDTH-1:0] result2_i,
    input  logic [OP_WIDTH-1:0]     op_func2_i,
    input  logic [TAG_WIDTH-1:0]    tag2_i,
    output logic                    ready2_o,
    output logic                    lsq_valid_o,
    input  logic                    lsq_ready_i,
    output logic [OPRAND_WIDTH-1:0] address_o,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic                    is_store_o,
    output logic                    lane_o
`ifdef LSQ_ARB_STATS_EN
    ,
    output logic [15:0]             grant1_cnt_o,
    output logic [15:0]             grant2_cnt_o,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    // Entry layout: {is_store, tag, address}
    localparam int c_ent_w = 1 + TAG_WIDTH + OPRAND_WIDTH;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

    state_t                  r_state;
    logic                    r_valid;
    logic [c_ent_w-1:0]      r_ent;
    logic                    r_lane;
    logic                    r_rr;

    logic [1:0]              w_valid_in;
    logic [1:0]              w_is_mem;
    logic [1:0][c_ent_w-1:0] w_ent_in;
    logic [1:0]              w_push;
    logic [1:0]              w_pop_lane;
    logic [1:0]              w_full;
    logic [1:0][c_cnt_w-1:0] w_cnt;
    logic [1:0][c_ent_w-1:0] w_head;
    logic [1:0][c_ent_w-1:0] w_next;
    logic                    w_pop;

    assign w_valid_in  = {valid2_i, valid1_i};
    assign w_is_mem[0] = (op_func1_i == LOAD) || (op_func1_i == STORE);
    assign w_is_mem[1] = (op_func2_i == LOAD) || (op_func2_i == STORE);
    assign w_ent_in[0] = {(op_func1_i == STORE), tag1_i, result1_i};
    assign w_ent_in[1] = {(op_func2_i == STORE), tag2_i, result2_i};

    // Flush takes priority over a handshake in the same cycle.
    assign w_pop = (r_state == S_OFFER) && lsq_ready_i && !flush_i;

    generate
        for (genvar l = 0; l < 2; l++) begin : g_lane
            logic [c_ent_w-1:0] r_mem [DEPTH];
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [c_cnt_w-1:0] r_cnt;

            // No dequeue bypass: a full FIFO refuses even while draining.
            assign w_full[l]     = (r_cnt == c_cnt_w'(DEPTH));
            assign w_push[l]     = w_valid_in[l] && w_is_mem[l] && !w_full[l] && !flush_i;
            assign w_pop_lane[l] = w_pop && (r_lane == 1'(l));
            assign w_cnt[l]      = r_cnt;
            assign w_head[l]     = r_mem[r_rd_ptr];
            assign w_next[l]     = r_mem[c_ptr_w'(r_rd_ptr + 1'b1)];

            always_ff @(posedge clk_i) begin
                if (w_push[l]) begin
                    r_mem[r_wr_ptr] <= w_ent_in[l];
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else if (flush_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push[l]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop_lane[l]) r_rd_ptr <= r_rd_ptr + 1'b1;
                    case ({w_push[l], w_pop_lane[l]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    // Next-grant selection. On a handshake the granted lane's head is being
    // popped, so its candidate becomes the following entry; entries pushed on
    // the same edge are not visible yet, which preserves the 1-cycle latency.
    logic [1:0]              w_avail;
    logic [1:0][c_ent_w-1:0] w_cand;
    logic                    w_rr_eff;
    logic                    w_sel_lane;
    logic                    w_sel_valid;
    logic [c_ent_w-1:0]      w_sel_ent;

    always_comb begin
        w_avail  = '0;
        w_cand   = '0;
        w_rr_eff = w_pop ? ~r_lane : r_rr;
        for (int l = 0; l < 2; l++) begin
            if (w_pop && (r_lane == 1'(l))) begin
                w_avail[l] = (w_cnt[l] > c_cnt_w'(1));
                w_cand[l]  = w_next[l];
            end else begin
                w_avail[l] = (w_cnt[l] != '0);
                w_cand[l]  = w_head[l];
            end
        end
        w_sel_valid = |w_avail;
        w_sel_lane  = (w_avail == 2'b11) ? w_rr_eff : w_avail[1];
        w_sel_ent   = w_cand[w_sel_lane];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ent   <= '0;
            r_lane  <= 1'b0;
            r_rr    <= 1'b0;
        end else if (flush_i) begin
            // Round-robin pointer survives a flush.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ent   <= '0;
            r_lane  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rr <= ~r_lane;
            end
            // In OFFER without ready the grant stays locked.
            if ((r_state == S_IDLE) || w_pop) begin
                if (w_sel_valid) begin
                    r_state <= S_OFFER;
                    r_valid <= 1'b1;
                    r_ent   <= w_sel_ent;
                    r_lane  <= w_sel_lane;
                end else begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ent   <= '0;
                    r_lane  <= 1'b0;
                end
            end
        end
    end

    assign ready1_o    = ~w_full[0];
    assign ready2_o    = ~w_full[1];
    assign lsq_valid_o = r_valid;
    assign address_o   = r_ent[OPRAND_WIDTH-1:0];
    assign tag_o       = r_ent[OPRAND_WIDTH +: TAG_WIDTH];
    assign is_store_o  = r_ent[c_ent_w-1];
    assign lane_o      = r_lane;

`ifdef LSQ_ARB_STATS_EN
    logic [15:0] r_grant1_cnt;
    logic [15:0] r_grant2_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant1_cnt <= '0;
            r_grant2_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_pop && !r_lane && (r_grant1_cnt != 16'hFFFF))
                r_grant1_cnt <= r_grant1_cnt + 1'b1;
            if (w_pop && r_lane && (r_grant2_cnt != 16'hFFFF))
                r_grant2_cnt <= r_grant2_cnt + 1'b1;
            if (r_valid && !lsq_ready_i && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign grant1_cnt_o = r_grant1_cnt;
    assign grant2_cnt_o = r_grant2_cnt;
    assign stall_cnt_o  = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsq_mem_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsq_mem_issue_arbiter
// Description : Directed self-checking bench for lsq_mem_issue_arbiter.
//               Inputs change 1 ns after the rising edge; outputs are checked
//               at that same point, well away from the next active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsq_mem_issue_arbiter;

    localparam logic [6:0] c_load  = 7'b0000011;
    localparam logic [6:0] c_store = 7'b0100011;
    localparam logic [6:0] c_addi  = 7'b0010011;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid1_i, valid2_i;
    logic [31:0] result1_i, result2_i;
    logic [6:0]  op_func1_i, op_func2_i;
    logic [5:0]  tag1_i, tag2_i;
    logic        ready1_o, ready2_o;
    logic        lsq_valid_o;
    logic        lsq_ready_i;
    logic [31:0] address_o;
    logic [5:0]  tag_o;
    logic        is_store_o;
    logic        lane_o;
`ifdef LSQ_ARB_STATS_EN
    logic [15:0] grant1_cnt_o, grant2_cnt_o, stall_cnt_o;
`endif

    int n_run  = 0;
    int n_fail = 0;

    lsq_mem_issue_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid1_i    (valid1_i),
        .result1_i   (result1_i),
        .op_func1_i  (op_func1_i),
        .tag1_i      (tag1_i),
        .ready1_o    (ready1_o),
        .valid2_i    (valid2_i),
        .result2_i   (result2_i),
        .op_func2_i  (op_func2_i),
        .tag2_i      (tag2_i),
        .ready2_o    (ready2_o),
        .lsq_valid_o (lsq_valid_o),
        .lsq_ready_i (lsq_ready_i),
        .address_o   (address_o),
        .tag_o       (tag_o),
        .is_store_o  (is_store_o),
        .lane_o      (lane_o)
`ifdef LSQ_ARB_STATS_EN
        ,
        .grant1_cnt_o(grant1_cnt_o),
        .grant2_cnt_o(grant2_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the full LSQ-side output bundle in one call.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [5:0] t, input logic s, input logic ln);
        chk({tag, ".valid"}, 64'(lsq_valid_o), 64'(v));
        chk({tag, ".addr"},  64'(address_o),   64'(a));
        chk({tag, ".tag"},   64'(tag_o),       64'(t));
        chk({tag, ".store"}, 64'(is_store_o),  64'(s));
        chk({tag, ".lane"},  64'(lane_o),      64'(ln));
    endtask

    task automatic idle_inputs();
        flush_i    = 1'b0;
        valid1_i   = 1'b0; result1_i = '0; op_func1_i = '0; tag1_i = '0;
        valid2_i   = 1'b0; result2_i = '0; op_func2_i = '0; tag2_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        lsq_ready_i = 1'b1;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        do_reset();

        // Reset state
        chk_out("rst", 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("rst.ready1", 64'(ready1_o), 64'd1);
        chk("rst.ready2", 64'(ready2_o), 64'd1);

        // 1: single load, 1-cycle minimum latency, no bypass
        valid1_i = 1'b1; op_func1_i = c_load; result1_i = 32'h1000; tag1_i = 6'd3;
        tick();
        idle_inputs();
        chk("t1.nobypass", 64'(lsq_valid_o), 64'd0);
        tick();
        chk_out("t1.offer", 1'b1, 32'h1000, 6'd3, 1'b0, 1'b0);
        tick();
        chk_out("t1.drained", 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);

        // 2: both lanes store in the same cycle, round-robin from lane 1
        do_reset();
        valid1_i = 1'b1; op_func1_i = c_store; result1_i = 32'hA0; tag1_i = 6'd1;
        valid2_i = 1'b1; op_func2_i = c_store; result2_i = 32'hB0; tag2_i = 6'd2;
        tick();
        idle_inputs();
        tick();
        chk_out("t2.first", 1'b1, 32'hA0, 6'd1, 1'b1, 1'b0);
        tick();
        chk_out("t2.second", 1'b1, 32'hB0, 6'd2, 1'b1, 1'b1);
        tick();
        chk("t2.drained", 64'(lsq_valid_o), 64'd0);

        // 3: lock on lane 2 while the LSQ stalls, lane 1 arrives meanwhile
        do_reset();
        lsq_ready_i = 1'b0;
        valid2_i = 1'b1; op_func2_i = c_load; result2_i = 32'h2000; tag2_i = 6'd5;
        tick();
        idle_inputs();
        tick();
        chk_out("t3.offer", 1'b1, 32'h2000, 6'd5, 1'b0, 1'b1);
        valid1_i = 1'b1; op_func1_i = c_load; result1_i = 32'h3000; tag1_i = 6'd7;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            chk_out("t3.locked", 1'b1, 32'h2000, 6'd5, 1'b0, 1'b1);
            tick();
        end
        chk_out("t3.locked", 1'b1, 32'h2000, 6'd5, 1'b0, 1'b1);
        lsq_ready_i = 1'b1;
        tick();
        chk_out("t3.next", 1'b1, 32'h3000, 6'd7, 1'b0, 1'b0);
        tick();
        chk("t3.drained", 64'(lsq_valid_o), 64'd0);

        // 4: lane 1 fills its FIFO; third push held off until a pop frees space
        do_reset();
        lsq_ready_i = 1'b0;
        valid1_i = 1'b1; op_func1_i = c_load; result1_i = 32'h10; tag1_i = 6'd1;
        tick();
        chk("t4.ready_after1", 64'(ready1_o), 64'd1);
        chk("t4.valid_after1", 64'(lsq_valid_o), 64'd0);
        result1_i = 32'h20; tag1_i = 6'd2;
        tick();
        chk("t4.full", 64'(ready1_o), 64'd0);
        chk_out("t4.head", 1'b1, 32'h10, 6'd1, 1'b0, 1'b0);
        result1_i = 32'h30; tag1_i = 6'd3;
        tick();
        chk("t4.still_full", 64'(ready1_o), 64'd0);
        chk_out("t4.head_held", 1'b1, 32'h10, 6'd1, 1'b0, 1'b0);
        lsq_ready_i = 1'b1;
        tick();
        chk("t4.ready_after_pop", 64'(ready1_o), 64'd1);
        chk_out("t4.b2b", 1'b1, 32'h20, 6'd2, 1'b0, 1'b0);
        tick();
        idle_inputs();
        chk("t4.gap", 64'(lsq_valid_o), 64'd0);
        chk("t4.ready_pushpop", 64'(ready1_o), 64'd1);
        tick();
        chk_out("t4.third", 1'b1, 32'h30, 6'd3, 1'b0, 1'b0);
        tick();
        chk("t4.drained", 64'(lsq_valid_o), 64'd0);

        // 5: non-memory opcode is filtered
        do_reset();
        valid2_i = 1'b1; op_func2_i = c_addi; result2_i = 32'h55; tag2_i = 6'd9;
        tick();
        chk("t5.ready2", 64'(ready2_o), 64'd1);
        chk("t5.valid", 64'(lsq_valid_o), 64'd0);
        tick();
        chk("t5.ready2_b", 64'(ready2_o), 64'd1);
        idle_inputs();
        tick();
        chk("t5.valid_b", 64'(lsq_valid_o), 64'd0);

        // 6: flush with two entries queued, flush wins over a same-cycle pop
        do_reset();
        lsq_ready_i = 1'b0;
        valid1_i = 1'b1; op_func1_i = c_load;  result1_i = 32'h40; tag1_i = 6'd4;
        valid2_i = 1'b1; op_func2_i = c_store; result2_i = 32'h50; tag2_i = 6'd6;
        tick();
        idle_inputs();
        tick();
        chk_out("t6.offer", 1'b1, 32'h40, 6'd4, 1'b0, 1'b0);
        lsq_ready_i = 1'b1;
        flush_i = 1'b1;
        valid1_i = 1'b1; op_func1_i = c_load; result1_i = 32'h60; tag1_i = 6'd8;
        tick();
        idle_inputs();
        chk_out("t6.flushed", 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();
        chk("t6.empty", 64'(lsq_valid_o), 64'd0);
        tick();
        chk("t6.empty_b", 64'(lsq_valid_o), 64'd0);

        // 7: asynchronous reset in the middle of an offer
        do_reset();
        lsq_ready_i = 1'b0;
        valid2_i = 1'b1; op_func2_i = c_store; result2_i = 32'h70; tag2_i = 6'd2;
        tick();
        idle_inputs();
        tick();
        chk_out("t7.offer", 1'b1, 32'h70, 6'd2, 1'b1, 1'b1);
        rst_i = 1'b1;
        #2;
        chk_out("t7.async", 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("t7.lost", 64'(lsq_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
